lsu_mem_master: RTL

- Initiator side of the core's physical-memory interface: converts one RV32 load/store request from the LSU into a word-aligned access on the DPI memory port (valid/wen/raddr/waddr/wdata/wmask/rdata).
- Read data is aligned, then sign- or zero-extended; the result returns over a valid/ready response channel.
- Sits between the EXU/LSU stage and the DPI-backed memory controller.
- Handles exactly one transaction at a time.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_load_align.sv | 18 +
 rtl/lsu_mem_master.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU types and helpers.
//   size_e      : access size encoding (byte/half/word; 3 is illegal)
//   state_e     : memory-master FSM states
//   lane_mask   : byte-lane strobe for a size at a byte offset
//   load_extend : align a read word to the access and sign/zero extend
//   misaligned  : request cannot be serviced (bad alignment or size)
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] lanes;
    case (size)
      SZ_B:    lanes = 4'b0001;
      SZ_H:    lanes = 4'b0011;
      SZ_W:    lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
    return lanes << off;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    res = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    res = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shifts the addressed bytes of a memory word
// down to bit 0 and sign/zero extends according to size.
//   word : raw read word       off  : byte offset within word
//   size : access size         uns  : 1 = zero-extend
//   data : extended result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  assign data = load_extend(word, off, size, uns);

endmodule

// File: rtl/lsu_mem_master.sv
// LSU memory master: turns one RV32 load/store request into a word-aligned
// access on the DPI memory port and returns the result on a valid/ready
// response channel. One transaction in flight at a time.
//   req_*  : request channel (valid/ready, wen, addr, wdata, size, unsigned)
//   resp_* : response channel (valid/ready, rdata, err)
//   mem_*  : memory port (valid, wen, raddr, waddr, wdata, wmask, rdata)
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int LAT    = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              wen_q, wen_d;
  logic              uns_q, uns_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       ld_data;
  logic              in_access;
  logic              last_cyc;
  logic [ADDR_W-1:0] word_addr;

  lsu_load_align u_align (
    .word (mem_rdata),
    .off  (addr_q[1:0]),
    .size (size_q),
    .uns  (uns_q),
    .data (ld_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    wen_d   = wen_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          wen_d   = req_wen;
          uns_d   = req_unsigned;
          if (misaligned(req_size, req_addr[1:0])) begin
            // Fault is reported without ever touching memory.
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = 4'(LAT - 1);
          end
        end
      end
      ST_ACCESS: begin
        if (last_cyc) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = wen_q ? '0 : ld_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory port is decoded straight from state flops so an async reset
  // drops it in the same instant.
  assign in_access = (state_q == ST_ACCESS);
  assign last_cyc  = (cnt_q == 4'd0);
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  assign mem_valid = in_access;
  assign mem_raddr = in_access ? word_addr : '0;
  assign mem_waddr = in_access ? word_addr : '0;
  // Write strobe only in the final cycle so a multi-cycle access writes once.
  assign mem_wen   = in_access & wen_q & last_cyc;
  assign mem_wdata = (in_access & wen_q) ? (wdata_q << {addr_q[1:0], 3'b000}) : '0;
  assign mem_wmask = (in_access & wen_q) ? {4'b0000, lane_mask(size_q, addr_q[1:0])} : '0;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
